// File: rtl/unified_mem_arbiter.sv
// Arbitrates the CPU and loader ports onto one single-port memory: one access strobe per grant, read data returned RD_LAT cycles later.
// Optional `ARB_LDR_PRIORITY_EN`: the loader wins every tie instead of round-robin.
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_done,
  input  logic              i_ldr_req,
  input  logic              i_ldr_we,
  input  logic [ADDR_W-1:0] i_ldr_addr,
  input  logic [DATA_W-1:0] i_ldr_wdata,
  output logic [DATA_W-1:0] o_ldr_rdata,
  output logic              o_ldr_done,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_grant_id
);

  generate
    if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
      $error("unified_mem_arbiter: RD_LAT must be in 1..7");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state;
  logic              r_we;
  logic              r_last_grant;
  logic [2:0]        r_cnt;
  logic              r_grant_id;
  logic              r_busy;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ldr_rdata;
  logic              r_cpu_done;
  logic              r_ldr_done;
  logic              w_any_req;
  logic              w_pick_ldr;

  assign w_any_req = i_cpu_req | i_ldr_req;

`ifdef ARB_LDR_PRIORITY_EN
  assign w_pick_ldr = i_ldr_req;
`else
  // On a tie the port that did not own the last grant wins.
  assign w_pick_ldr = i_ldr_req & (~i_cpu_req | ~r_last_grant);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= 3'd0;
      r_grant_id   <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rdata  <= '0;
      r_ldr_rdata  <= '0;
      r_cpu_done   <= 1'b0;
      r_ldr_done   <= 1'b0;
    end else begin
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_cpu_done <= 1'b0;
      r_ldr_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant_id   <= w_pick_ldr;
            r_last_grant <= w_pick_ldr;
            r_we         <= w_pick_ldr ? i_ldr_we : i_cpu_we;
            r_mem_we     <= w_pick_ldr ? i_ldr_we : i_cpu_we;
            r_mem_addr   <= w_pick_ldr ? i_ldr_addr : i_cpu_addr;
            r_mem_wdata  <= w_pick_ldr ? i_ldr_wdata : i_cpu_wdata;
            r_mem_en     <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_we) begin
            r_cpu_done <= ~r_grant_id;
            r_ldr_done <= r_grant_id;
            r_state    <= RESP;
          end else begin
            r_cnt   <= 3'(RD_LAT);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 3'd1) begin
            if (r_grant_id) r_ldr_rdata <= i_mem_rdata;
            else            r_cpu_rdata <= i_mem_rdata;
            r_cpu_done <= ~r_grant_id;
            r_ldr_done <= r_grant_id;
            r_state    <= RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_done  = r_cpu_done;
  assign o_ldr_rdata = r_ldr_rdata;
  assign o_ldr_done  = r_ldr_done;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = r_busy;
  assign o_grant_id  = r_grant_id;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: a transaction-timeline model checked every cycle, plus directed literal checks.
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
  logic [AW-1:0] cpu_addr = '0, ldr_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, ldr_wdata = '0;
  logic [DW-1:0] cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          cpu_done, ldr_done, mem_en, mem_we, busy, grant_id;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_done(cpu_done),
    .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr), .i_ldr_wdata(ldr_wdata),
    .o_ldr_rdata(ldr_rdata), .o_ldr_done(ldr_done),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_busy(busy), .o_grant_id(grant_id)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Unwritten locations read back a known address-dependent pattern; 0x10 reads 0xDEADBEEF.
  function automatic logic [31:0] dflt(input logic [7:0] a);
    return 32'hDEADBEEF ^ {24'd0, a ^ 8'h10};
  endfunction

  // Memory macro: read data appears RL cycles after the strobe, junk otherwise.
  logic [31:0] bmem [256];
  bit          bwr  [256];
  logic [31:0] pipe [RL];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      bmem[mem_addr[7:0]] <= mem_wdata;
      bwr[mem_addr[7:0]]  <= 1'b1;
    end
    pipe[0] <= (mem_en && !mem_we) ? (bwr[mem_addr[7:0]] ? bmem[mem_addr[7:0]] : dflt(mem_addr[7:0]))
                                   : 32'hBAD0BAD0;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RL-1];

  // Model: each grant starts a timeline; age 1 is the strobe cycle, done lands at age 2 (write) or RL+2 (read).
  int          m_age;
  logic        m_owner, m_last, m_we;
  logic [31:0] m_addr, m_wdata, m_newrd;
  logic [31:0] m_rd [2];
  logic [31:0] rmem [256];
  bit          rwr  [256];

  function automatic int fin_age(input logic we);
    return we ? 2 : RL + 2;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_age = 0; m_owner = 0; m_last = 1; m_we = 0; m_addr = 0; m_wdata = 0;
      m_rd[0] = 0; m_rd[1] = 0;
    end else if (m_age == 0) begin
      if (cpu_req || ldr_req) begin
`ifdef ARB_LDR_PRIORITY_EN
        m_owner = ldr_req;
`else
        m_owner = (cpu_req && ldr_req) ? !m_last : ldr_req;
`endif
        m_last  = m_owner;
        m_we    = m_owner ? ldr_we : cpu_we;
        m_addr  = m_owner ? ldr_addr : cpu_addr;
        m_wdata = m_owner ? ldr_wdata : cpu_wdata;
        if (m_we) begin
          rmem[m_addr[7:0]] = m_wdata;
          rwr[m_addr[7:0]]  = 1'b1;
        end else begin
          m_newrd = rwr[m_addr[7:0]] ? rmem[m_addr[7:0]] : dflt(m_addr[7:0]);
        end
        m_age = 1;
      end
    end else if (m_age == fin_age(m_we)) begin
      m_age = 0;
    end else begin
      m_age++;
      if (!m_we && m_age == fin_age(m_we)) m_rd[m_owner] = m_newrd;
    end
  end

  int cdone = 0, ldone = 0, men = 0;
  int order [$];

  always @(negedge clk) begin
    logic done_now;
    done_now = (m_age != 0) && (m_age == fin_age(m_we));
    chk("busy", 32'(busy), 32'(m_age != 0));
    chk("grant_id", 32'(grant_id), 32'(m_owner));
    chk("mem_en", 32'(mem_en), 32'(m_age == 1));
    chk("mem_we", 32'(mem_we), 32'(m_age == 1 && m_we));
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("cpu_done", 32'(cpu_done), 32'(done_now && !m_owner));
    chk("ldr_done", 32'(ldr_done), 32'(done_now && m_owner));
    chk("cpu_rdata", cpu_rdata, m_rd[0]);
    chk("ldr_rdata", ldr_rdata, m_rd[1]);
    if (cpu_done === 1'b1) begin cdone++; order.push_back(0); end
    if (ldr_done === 1'b1) begin ldone++; order.push_back(1); end
    if (mem_en === 1'b1) men++;
  end

  task automatic start(input bit port, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    if (port) begin ldr_we = we; ldr_addr = addr; ldr_wdata = wd; ldr_req = 1'b1; end
    else      begin cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1; end
  endtask

  // Waits for the port's done (bounded), then drops req on the edge ending the done cycle.
  task automatic finish(input bit port, input bit scr, output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (scr && k == 1) begin
        if (port) begin ldr_addr = 32'hFFFF_FFF0; ldr_wdata = 32'h0BAD0BAD; ldr_we = ~ldr_we; end
        else      begin cpu_addr = 32'hFFFF_FFF0; cpu_wdata = 32'h0BAD0BAD; cpu_we = ~cpu_we; end
      end
      if ((port ? ldr_done : cpu_done) === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL timeout port=%0d: no done within 40 cycles", port);
    end else begin
      @(posedge clk); #1;
      if (port) ldr_req = 1'b0; else cpu_req = 1'b0;
    end
  endtask

  task automatic access(input bit port, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input bit scr, output int lat);
    @(posedge clk); #1;
    start(port, we, addr, wd);
    finish(port, scr, lat);
  endtask

  task automatic pair(input logic [31:0] ca, input logic [31:0] la, output int lc, output int ll);
    int a, b;
    @(posedge clk); #1;
    start(0, 1'b0, ca, 32'd0);
    start(1, 1'b0, la, 32'd0);
    fork
      finish(0, 1'b0, a);
      finish(1, 1'b0, b);
    join
    lc = a; ll = b;
  endtask

  initial begin
    int lat, lc, ll, c0, l0, e0;
    int exp_order [4];
    int exp_first, exp_second;

    @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // CPU read of 0x10, fields scrambled after the grant
    c0 = cdone; l0 = ldone; e0 = men;
    access(0, 1'b0, 32'h10, 32'h0, 1'b1, lat);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t1_mem_en_cycles", 32'(men - e0), 32'd1);
    chk("t1_ldr_done_count", 32'(ldone - l0), 32'd0);

    // CPU write 0x20 <- 0x12345678
    e0 = men;
    access(0, 1'b1, 32'h20, 32'h12345678, 1'b1, lat);
    chk("t2_latency", 32'(lat), 32'd2);
    chk("t2_cpu_rdata_kept", cpu_rdata, 32'hDEADBEEF);
    chk("t2_mem_en_cycles", 32'(men - e0), 32'd1);
    chk("t2_mem_content", bmem[8'h20], 32'h12345678);

    // Simultaneous requests after a fresh reset
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    order.delete();
    pair(32'h40, 32'h41, lc, ll);
    pair(32'h42, 32'h43, lc, ll);
`ifdef ARB_LDR_PRIORITY_EN
    exp_order = '{1, 0, 1, 0};
    exp_first = 9; exp_second = 4;
`else
    exp_order = '{0, 1, 0, 1};
    exp_first = 4; exp_second = 9;
`endif
    chk("t3_order_len", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_order[%0d]", i), 32'(i < order.size() ? order[i] : 9), 32'(exp_order[i]));
    chk("t3_cpu_latency", 32'(lc), 32'(exp_first));
    chk("t3_ldr_latency", 32'(ll), 32'(exp_second));
    chk("t3_cpu_rdata", cpu_rdata, 32'hDEADBEBD);
    chk("t3_ldr_rdata", ldr_rdata, 32'hDEADBEBC);

    // Reset during the WAIT of a CPU read
    c0 = cdone;
    @(posedge clk); #1;
    start(0, 1'b0, 32'h30, 32'd0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1; cpu_req = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_mem_en", 32'(mem_en), 32'd0);
    chk("t5_cpu_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    chk("t5_no_done", 32'(cdone - c0), 32'd0);
    access(0, 1'b0, 32'h30, 32'd0, 1'b0, lat);
    chk("t5_retry_latency", 32'(lat), 32'd4);
    chk("t5_retry_rdata", cpu_rdata, 32'hDEADBECF);

    // Loader burst of writes, then CPU readback
    l0 = ldone;
    for (int i = 0; i < 4; i++) begin
      access(1, 1'b1, 32'(i), 32'hA0 + 32'(i), 1'b0, lat);
      chk($sformatf("t6_wr_latency[%0d]", i), 32'(lat), 32'd2);
    end
    chk("t6_ldr_done_count", 32'(ldone - l0), 32'd4);
    access(0, 1'b0, 32'h2, 32'd0, 1'b0, lat);
    chk("t6_cpu_rdata", cpu_rdata, 32'hA2);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares the single-port unified instruction/data memory of the multicycle core between two requesters:
  - the core's memory interface (CPU port);
  - the program loader / debug port (LDR port).
- Accepts level-held requests, grants one at a time, and drives the memory for exactly one access cycle.
- Waits out the memory read latency, then returns data with a one-cycle done pulse.
- Sits between the core's address/data muxing and the memory macro.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RD_LAT, 1, cycles from mem_en to valid mem_rdata; legal 1..7

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, level
cpu_we  in  1  CPU write enable (1=write, 0=read)
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, registered
cpu_done  out  1  CPU access complete, 1-cycle pulse
ldr_req  in  1  loader request, level
ldr_we  in  1  loader write enable
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  DATA_W  loader write data
ldr_rdata  out  DATA_W  loader read data, registered
ldr_done  out  1  loader access complete, 1-cycle pulse
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state != IDLE
grant_id  out  1  current/last owner: 0=CPU, 1=LDR

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset values:
  - state=IDLE.
  - All outputs 0, including cpu_rdata and ldr_rdata.
  - last_grant=LDR, so the CPU wins the first tie.
- State IDLE:
  - Sample requests. If any req is high: pick a winner, latch its we/addr/wdata into internal regs, set grant_id, go to ISSUE.
  - If no req is high: stay in IDLE.
- Arbitration:
  - Single requester wins.
  - Both requesting: round-robin, winner = port not equal to last_grant.
  - last_grant updates on every grant.
- State ISSUE (exactly 1 cycle):
  - mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values.
  - Write: go to RESP.
  - Read: load counter with RD_LAT, go to WAIT.
- State WAIT:
  - mem_en=0, mem_we=0. Counter decrements each cycle.
  - When counter==1: capture mem_rdata into the owner's rdata register, go to RESP.
  - With ISSUE at cycle t, capture occurs at cycle t+RD_LAT.
- State RESP (1 cycle):
  - The owner's done=1; the other port's done stays 0.
  - Go to IDLE.
- Latency, measured from the IDLE cycle where req is sampled to the done cycle:
  - read: RD_LAT+2 cycles;
  - write: 2 cycles.
- Requester rules:
  - Request fields may change after grant; only latched values are used.
  - Requester drops req on the edge ending its done cycle.
  - req high in IDLE is always treated as a new request.
- Non-owner req stays pending during an access and is served next from IDLE. No preemption.
- Read data registers:
  - cpu_rdata/ldr_rdata hold their value until that port's next read completes.
  - Writes do not alter them.
- mem_addr/mem_wdata are held at the latched values outside ISSUE (don't-care to memory); mem_en/mem_we are 0 outside ISSUE.
- busy = (state != IDLE). grant_id holds its value in IDLE.
- Reset mid-operation (any state):
  - Immediate return to IDLE with all outputs 0. No done is issued.
  - An interrupted access is not retried.
- RD_LAT outside 1..7 is a configuration error (elaboration assertion).

Optional Feature:
- Macro: ARB_LDR_PRIORITY_EN.
- Defined: fixed priority. When both request in IDLE, LDR always wins; last_grant is ignored for ties.
- Undefined: round-robin as above.
- All other behaviour is identical in both cases.

Test Plan:
1. Reset, RD_LAT=2, CPU read 0x10, memory model returns 0xDEADBEEF -> one mem_en cycle with mem_addr=0x10, mem_we=0; cpu_done 4 cycles after req sampled; cpu_rdata=0xDEADBEEF; ldr_done stays 0.
2. CPU write 0x20 <- 0x12345678 -> single cycle with mem_en=mem_we=1, mem_addr=0x20, mem_wdata=0x12345678; cpu_done 2 cycles after req; cpu_rdata unchanged.
3. cpu_req and ldr_req rise together twice (reads, round-robin build) -> first pair: CPU then LDR; second pair: CPU then LDR (alternation); grant_id follows 0,1,0,1.
4. Same stimulus with ARB_LDR_PRIORITY_EN defined -> LDR served first in both pairs.
5. Reset asserted during WAIT of a CPU read -> busy=0, mem_en=0 and cpu_rdata=0 immediately; no cpu_done; next CPU read completes normally.
6. LDR writes 0xA0..0xA3 to addresses 0..3 back-to-back, then CPU reads address 2 -> cpu_rdata=0xA2; every LDR write completes with one ldr_done each.
